// File: rtl/deserializer_9_outputs.sv
// ---------------------------------------------------------------------------
// deserializer_9_outputs
//
// Collects 9 serial bits and presents them as one 9-bit parallel word.
// Each bit position can be inverted at the output through BubblesMask.
// The finished word is held until the consumer takes it. The next word is
// shifted in while the previous one is still held.
//
// Parameters
//   BubblesMask : 9-bit mask; a 1 in bit i inverts Result[i]
//   LsbFirst    : 1 -> first accepted bit lands in Result[0],
//                 0 -> first accepted bit lands in Result[8]
//
// Ports
//   Clock    : in   single clock, rising edge
//   Reset    : in   asynchronous, active-high; clears all state
//   Clear    : in   synchronous; discards the partial word only
//   SerialIn : in   serial data bit
//   InValid  : in   SerialIn is valid this cycle
//   InReady  : out  block accepts a bit this cycle
//   Result   : out  held word XOR BubblesMask
//   OutValid : out  Result holds a complete, unconsumed word
//   OutReady : in   consumer accepts Result this cycle
//   BitCount : out  bits in the current partial word (0..8)
//
// Handshake semantics
//   An input bit transfers on a rising edge when InValid && InReady (and
//   Clear is low). A word transfers out when OutValid && OutReady. InReady
//   depends only on state and OutReady, never on InValid. It drops only when
//   the 9th bit would overwrite a word the consumer has not yet taken.
//
// Observable state
//   {OutValid, BitCount} is the full control state.
//   EMPTY   = {0, 0}
//   FILLING = BitCount 1..8
//   HOLD    = OutValid 1
//   HOLD and FILLING can be active at the same time.
// ---------------------------------------------------------------------------
module deserializer_9_outputs #(
  parameter logic [8:0] BubblesMask = 9'h000,
  parameter bit         LsbFirst    = 1'b1
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Clear,
  input  logic       SerialIn,
  input  logic       InValid,
  output logic       InReady,
  output logic [8:0] Result,
  output logic       OutValid,
  input  logic       OutReady,
  output logic [3:0] BitCount
);

  logic [8:0] shift_q;
  logic [8:0] hold_q;
  logic [3:0] count_q;
  logic       valid_q;

  logic       last_bit;
  logic       in_fire;
  logic       out_fire;
  logic [3:0] pos;
  logic [8:0] word_next;

  always_comb begin
    last_bit  = (count_q == 4'd8);
    // Clear discards a same-cycle input transfer.
    in_fire   = InValid && InReady && !Clear;
    out_fire  = valid_q && OutReady;
    pos       = LsbFirst ? count_q : (4'd8 - count_q);
    // The word including the current bit. On the 9th bit, this value goes
    // straight to the hold register, so the word is visible at that edge.
    word_next = shift_q;
    word_next[pos] = SerialIn;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      shift_q <= '0;
      hold_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      if (Clear) begin
        count_q <= '0;
      end else if (in_fire) begin
        if (last_bit) begin
          hold_q  <= word_next;
          count_q <= '0;
        end else begin
          shift_q <= word_next;
          count_q <= count_q + 4'd1;
        end
      end
      // A new word arriving while the old one is taken keeps OutValid high.
      if (in_fire && last_bit) begin
        valid_q <= 1'b1;
      end else if (out_fire) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign InReady  = !(last_bit && valid_q && !OutReady);
  assign Result   = hold_q ^ BubblesMask;
  assign OutValid = valid_q;
  assign BitCount = count_q;

endmodule

// File: tb/tb_deserializer_9_outputs.sv
// ---------------------------------------------------------------------------
// tb_deserializer_9_outputs
//
// This bench drives four instances from the same inputs:
//   dut_a : BubblesMask=000, LsbFirst=1 (reference)
//   dut_b : BubblesMask=1A5, LsbFirst=1
//   dut_c : BubblesMask=000, LsbFirst=0
//   dut_d : BubblesMask=1FF, LsbFirst=1
//
// Expected raw words (LSB-first assembly of the accepted bits) are queued when
// the 9th bit is accepted. They are popped when an output transfer is seen.
// Each instance's expected Result is derived from the raw word.
// ---------------------------------------------------------------------------
module tb_deserializer_9_outputs;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       Clear;
  logic       SerialIn;
  logic       InValid;
  logic       OutReady;

  logic       ir_a, ir_b, ir_c, ir_d;
  logic       ov_a, ov_b, ov_c, ov_d;
  logic [8:0] res_a, res_b, res_c, res_d;
  logic [3:0] bc_a, bc_b, bc_c, bc_d;

  int         checks   = 0;
  int         failures = 0;

  logic [8:0] exp_q[$];
  logic [8:0] cur_bits;
  int         cnt = 0;
  bit         auto_release = 1'b0;

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  deserializer_9_outputs #(.BubblesMask(9'h000), .LsbFirst(1'b1)) dut_a (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .SerialIn(SerialIn),
    .InValid(InValid), .InReady(ir_a), .Result(res_a), .OutValid(ov_a),
    .OutReady(OutReady), .BitCount(bc_a));

  deserializer_9_outputs #(.BubblesMask(9'h1A5), .LsbFirst(1'b1)) dut_b (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .SerialIn(SerialIn),
    .InValid(InValid), .InReady(ir_b), .Result(res_b), .OutValid(ov_b),
    .OutReady(OutReady), .BitCount(bc_b));

  deserializer_9_outputs #(.BubblesMask(9'h000), .LsbFirst(1'b0)) dut_c (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .SerialIn(SerialIn),
    .InValid(InValid), .InReady(ir_c), .Result(res_c), .OutValid(ov_c),
    .OutReady(OutReady), .BitCount(bc_c));

  deserializer_9_outputs #(.BubblesMask(9'h1FF), .LsbFirst(1'b1)) dut_d (
    .Clock(Clock), .Reset(Reset), .Clear(Clear), .SerialIn(SerialIn),
    .InValid(InValid), .InReady(ir_d), .Result(res_d), .OutValid(ov_d),
    .OutReady(OutReady), .BitCount(bc_d));

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [8:0] rev9(input logic [8:0] w);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) r[i] = w[8-i];
    return r;
  endfunction

  // ---------------- scoreboard monitor ----------------
  // An output transfer happens at the next rising edge when OutValid &&
  // OutReady at the falling edge. Inputs never change at the falling edge.
  always @(negedge Clock) begin
    logic [8:0] w;
    if (!Reset && ov_a && OutReady) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_word", exp_q.size(), 1);
      end else begin
        w = exp_q.pop_front();
        check_eq("word_a", res_a, w);
        check_eq("word_b", res_b, w ^ 9'h1A5);
        check_eq("word_c", res_c, rev9(w));
        check_eq("word_d", res_d, w ^ 9'h1FF);
        check_eq("ov_all", {ov_b, ov_c, ov_d}, 3'b111);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Bookkeeping after a bit has been accepted at the last rising edge.
  task automatic accept_bit(input logic b);
    logic [8:0] w;
    cur_bits[cnt] = b;
    if (cnt == 8) begin
      w = cur_bits;
      exp_q.push_back(w);
      cnt = 0;
      check_eq("ov_on_9th", ov_a, 1);
      check_eq("res_on_9th", res_a, w);
    end else begin
      cnt++;
    end
    check_eq("bit_count", bc_a, cnt);
  endtask

  task automatic send_bit(input logic b);
    int waits;
    waits = 0;
    InValid  = 1'b1;
    SerialIn = b;
    #1;
    while (!ir_a && waits < 50) begin
      @(posedge Clock); #1;
      waits++;
      if (auto_release && waits >= 3) OutReady = 1'b1;
      #1;
    end
    if (!ir_a) begin
      check_eq("in_ready_timeout", ir_a, 1);
      InValid = 1'b0;
      return;
    end
    @(posedge Clock); #1;
    InValid = 1'b0;
    accept_bit(b);
  endtask

  task automatic send_word(input logic [8:0] w);
    for (int i = 0; i < 9; i++) send_bit(w[i]);
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_res_a"}, res_a, 9'h000);
    check_eq({tag, "_res_b"}, res_b, 9'h1A5);
    check_eq({tag, "_res_d"}, res_d, 9'h1FF);
    check_eq({tag, "_ov"}, {ov_a, ov_b, ov_c, ov_d}, 4'b0000);
    check_eq({tag, "_ir"}, {ir_a, ir_b, ir_c, ir_d}, 4'b1111);
    check_eq({tag, "_bc"}, bc_a, 0);
  endtask

  // Reset is raised between edges and checked before the next edge.
  task automatic do_async_reset(input string tag);
    #2 Reset = 1'b1;
    #1;
    check_reset_vals(tag);
    exp_q.delete();
    cnt = 0;
    @(posedge Clock); #1;
    Reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [8:0] word1;
    logic [8:0] word2;
    Reset = 1'b1; Clear = 1'b0; SerialIn = 1'b0; InValid = 1'b0;
    OutReady = 1'b1;
    #1;
    check_reset_vals("reset");
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(posedge Clock); #1;

    // Known stream 1,0,1,0,0,1,0,1,1 with the consumer always ready.
    send_word(9'h1A5);
    check_eq("t2_res_a", res_a, 9'h1A5);
    check_eq("t2_res_c", res_c, 9'h14B);
    check_eq("t2_res_d", res_d, 9'h05A);
    @(posedge Clock); #1;
    check_eq("t2_ov_drop", ov_a, 0);
    check_eq("t2_res_kept", res_a, 9'h1A5);

    // Backpressure: two words with the consumer stalled.
    OutReady = 1'b0;
    word1 = 9'h0C3;
    word2 = 9'h13A;
    send_word(word1);
    for (int i = 0; i < 8; i++) send_bit(word2[i]);
    check_eq("bp_bc8", bc_a, 8);
    InValid  = 1'b1;
    SerialIn = word2[8];
    #1;
    check_eq("bp_stall", ir_a, 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge Clock); #1;
      check_eq("bp_hold_bc", bc_a, 8);
      check_eq("bp_hold_ov", ov_a, 1);
      check_eq("bp_hold_res", res_a, word1);
    end
    OutReady = 1'b1;
    #1;
    check_eq("bp_release", ir_a, 1);
    @(posedge Clock); #1;
    InValid = 1'b0;
    accept_bit(word2[8]);
    check_eq("bp_word2", res_a, word2);
    @(posedge Clock); #1;

    // Clear drops the partial word and the bit presented with it.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    repeat (10) @(posedge Clock);
    #1;
    check_eq("idle_keep", bc_a, 5);
    Clear = 1'b1; InValid = 1'b1; SerialIn = 1'b1;
    @(posedge Clock); #1;
    Clear = 1'b0; InValid = 1'b0;
    check_eq("clear_bc", bc_a, 0);
    cnt = 0;
    send_word(9'h0F0);
    check_eq("after_clear", res_a, 9'h0F0);
    @(posedge Clock); #1;

    // Reset in the middle of a word.
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    check_eq("mid_bc4", bc_a, 4);
    do_async_reset("rst_mid");

    // Reset while a word is held.
    OutReady = 1'b0;
    send_word(9'h1C7);
    check_eq("held_ov", ov_a, 1);
    do_async_reset("rst_hold");
    OutReady = 1'b1;
    @(posedge Clock); #1;

    // Random bits with a random consumer.
    auto_release = 1'b1;
    for (int i = 0; i < 60; i++) begin
      OutReady = 1'($urandom_range(0, 1));
      send_bit(1'($urandom_range(0, 1)));
    end
    OutReady = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("final_bc", bc_a, cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
